// File: rtl/tis_node_exec.sv
// rtl/tis_node_exec.sv - TIS-100 node execute stage with ACC/BAK and blocking neighbour ports
//
// Purpose: decodes the 21-bit instr_rom word, owns ACC and BAK, performs the
// saturating node arithmetic and the blocking valid/ready port transfers, and
// returns op/acc/jmp_off plus the pc_en completion strobe to instr_rom.
//
// Ports:
//   clk        system clock, all state on posedge
//   reset      synchronous active-low reset
//   instr      {opcode[20:17], src[16:14], dst[13:11], imm[10:0]}
//   pc_en      instruction-complete strobe (instr_rom clk_en)
//   op         opcode field of instr
//   acc        current ACC value (signed)
//   jmp_off    jump offset: imm for JMP..JLZ, source operand for JRO, else 0
//   in_data    neighbour input data, direction d at [d*ACC_W +: ACC_W]
//   in_valid   per-direction input valid (0 LEFT, 1 RIGHT, 2 UP, 3 DOWN)
//   in_ready   per-direction input ready, one-hot while reading a port
//   out_data   outgoing port data, shared by all directions
//   out_valid  per-direction output valid, one-hot while writing a port
//   out_ready  per-direction output ready
module tis_node_exec #(
  parameter int ACC_W   = 11,
  parameter int ACC_MAX = 999
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [20:0]             instr,
  output logic                    pc_en,
  output logic [3:0]              op,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] jmp_off,
  input  logic [4*ACC_W-1:0]      in_data,
  input  logic [3:0]              in_valid,
  output logic [3:0]              in_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [3:0]              out_valid,
  input  logic [3:0]              out_ready
);

  localparam logic [0:0] S_EXEC  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_SWP = 4'd2;
  localparam logic [3:0] OP_SAV = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_NEG = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_JLZ = 4'd11;
  localparam logic [3:0] OP_JRO = 4'd12;

  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(ACC_MAX);
  localparam logic signed [ACC_W:0] SAT_LO = -SAT_HI;

  logic [0:0]              r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_bak;
  logic signed [ACC_W-1:0] r_hold;

  logic [3:0]              w_op;
  logic [2:0]              w_src;
  logic [2:0]              w_dst;
  logic signed [ACC_W-1:0] w_imm;
  logic signed [ACC_W-1:0] w_operand;
  logic                    w_uses_src;
  logic                    w_src_port;
  logic [1:0]              w_src_idx;
  logic                    w_dst_port;
  logic [1:0]              w_dst_idx;
  logic                    w_operand_ok;
  logic                    w_mov_port;
  logic signed [ACC_W:0]   w_acc_x;
  logic signed [ACC_W:0]   w_opnd_x;

  // Clamp a one-bit-wider intermediate back into [-ACC_MAX, ACC_MAX].
  function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W:0] v);
    logic signed [ACC_W:0] c;
    if (v > SAT_HI)      c = SAT_HI;
    else if (v < SAT_LO) c = SAT_LO;
    else                 c = v;
    return c[ACC_W-1:0];
  endfunction

  assign w_op  = instr[20:17];
  assign w_src = instr[16:14];
  assign w_dst = instr[13:11];
  assign w_imm = ACC_W'($signed(instr[10:0]));

  assign w_uses_src = (w_op == OP_MOV) || (w_op == OP_ADD) ||
                      (w_op == OP_SUB) || (w_op == OP_JRO);

  // Source decode: port sources only count for opcodes that read src, so
  // e.g. a NOP with a port src field never asserts in_ready or stalls.
  always_comb begin
    w_src_port = 1'b0;
    w_src_idx  = 2'd0;
    w_operand  = '0;
    case (w_src)
      3'd0:    w_operand = w_imm;
      3'd1:    w_operand = r_acc;
      3'd3:    begin w_src_port = 1'b1; w_src_idx = 2'd0; end
      3'd4:    begin w_src_port = 1'b1; w_src_idx = 2'd1; end
      3'd5:    begin w_src_port = 1'b1; w_src_idx = 2'd2; end
      3'd6:    begin w_src_port = 1'b1; w_src_idx = 2'd3; end
      default: ;
    endcase
    if (w_src_port) w_operand = in_data[w_src_idx*ACC_W +: ACC_W];
    if (!w_uses_src) w_src_port = 1'b0;
  end

  always_comb begin
    w_dst_port = 1'b0;
    w_dst_idx  = 2'd0;
    case (w_dst)
      3'd2:    begin w_dst_port = 1'b1; w_dst_idx = 2'd0; end
      3'd3:    begin w_dst_port = 1'b1; w_dst_idx = 2'd1; end
      3'd4:    begin w_dst_port = 1'b1; w_dst_idx = 2'd2; end
      3'd5:    begin w_dst_port = 1'b1; w_dst_idx = 2'd3; end
      default: ;
    endcase
  end

  assign w_operand_ok = !w_src_port || in_valid[w_src_idx];
  assign w_mov_port   = (w_op == OP_MOV) && w_dst_port;
  assign w_acc_x      = {r_acc[ACC_W-1], r_acc};
  assign w_opnd_x     = {w_operand[ACC_W-1], w_operand};

  always_comb begin
    in_ready = 4'b0000;
    if (reset && (r_state == S_EXEC) && w_src_port) in_ready[w_src_idx] = 1'b1;
  end

  always_comb begin
    out_valid = 4'b0000;
    if (reset && (r_state == S_WRITE)) out_valid[w_dst_idx] = 1'b1;
  end

  // instr is held stable during WRITE because pc_en stays low, so the dst
  // decode remains valid for the whole write handshake.
  always_comb begin
    pc_en = 1'b0;
    if (reset) begin
      if (r_state == S_EXEC) pc_en = w_operand_ok && !w_mov_port;
      else                   pc_en = out_ready[w_dst_idx];
    end
  end

  always_comb begin
    jmp_off = '0;
    if ((w_op >= OP_JMP) && (w_op <= OP_JLZ)) jmp_off = w_imm;
    else if (w_op == OP_JRO)                  jmp_off = w_operand;
  end

  assign op       = w_op;
  assign acc      = r_acc;
  assign out_data = r_hold;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_EXEC;
      r_acc   <= '0;
      r_bak   <= '0;
      r_hold  <= '0;
    end else if (r_state == S_EXEC) begin
      if (w_operand_ok) begin
        if (w_mov_port) begin
          // Port destination: latch the value, finish in WRITE.
          r_hold  <= w_operand;
          r_state <= S_WRITE;
        end else begin
          case (w_op)
            OP_MOV:  if (w_dst == 3'd0) r_acc <= sat(w_opnd_x);
            OP_SWP:  begin r_acc <= r_bak; r_bak <= r_acc; end
            OP_SAV:  r_bak <= r_acc;
            OP_ADD:  r_acc <= sat(w_acc_x + w_opnd_x);
            OP_SUB:  r_acc <= sat(w_acc_x - w_opnd_x);
            OP_NEG:  r_acc <= -r_acc;
            default: ;
          endcase
        end
      end
    end else begin
      if (out_ready[w_dst_idx]) r_state <= S_EXEC;
    end
  end

endmodule
